// File: rtl/i2c_slave_byte_ctrl.sv
// Byte-level I2C responder for one 7-bit address: START/STOP detection, address match, ACK, and byte RX/TX.
// Define I2C_SLAVE_GENERAL_CALL_EN to also ACK the general-call address byte 8'h00.
module i2c_slave_byte_ctrl #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Scl_i,
    input  logic       Sda_i,
    output logic       Sda_oen,
    output logic [7:0] Rx_data,
    output logic       Rx_valid,
    input  logic       Rx_nack,
    input  logic [7:0] Tx_data,
    output logic       Tx_req,
    output logic       Addr_match,
    output logic       Rw,
    output logic       Master_nack,
    output logic       Stop_det,
    output logic       Busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] scl_sync, sda_sync;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [6:0] shift_reg, shift_nxt;
    logic       byte_done, byte_done_nxt;
    logic       sda_oen_nxt, rw_nxt;
    logic [7:0] rx_data_nxt, new_byte;
    logic       rx_valid_nxt, tx_req_nxt, addr_match_nxt, master_nack_nxt, stop_det_nxt;
    logic       scl_s, scl_d, sda_s, sda_d;
    logic       scl_rise, scl_fall, start_cond, stop_cond, addr_hit;

    // Two synchronizer stages plus one delay stage per pad; bit 1 is the synced level.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            scl_sync <= {scl_sync[1:0], Scl_i};
            sda_sync <= {sda_sync[1:0], Sda_i};
        end
    end

    assign scl_s      = scl_sync[1];
    assign scl_d      = scl_sync[2];
    assign sda_s      = sda_sync[1];
    assign sda_d      = sda_sync[2];
    assign scl_rise   = scl_s & ~scl_d;
    assign scl_fall   = ~scl_s & scl_d;
    assign start_cond = ~sda_s & sda_d & scl_s;
    assign stop_cond  = sda_s & ~sda_d & scl_s;
    assign new_byte   = {shift_reg, sda_s};
    assign Busy       = (state != IDLE);

`ifdef I2C_SLAVE_GENERAL_CALL_EN
    assign addr_hit = (new_byte[7:1] == SLAVE_ADDR) || (new_byte == 8'h00);
`else
    assign addr_hit = (new_byte[7:1] == SLAVE_ADDR);
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            shift_reg   <= 7'd0;
            byte_done   <= 1'b0;
            Sda_oen     <= 1'b1;
            Rx_data     <= 8'h00;
            Rw          <= 1'b0;
            Rx_valid    <= 1'b0;
            Tx_req      <= 1'b0;
            Addr_match  <= 1'b0;
            Master_nack <= 1'b0;
            Stop_det    <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shift_reg   <= shift_nxt;
            byte_done   <= byte_done_nxt;
            Sda_oen     <= sda_oen_nxt;
            Rx_data     <= rx_data_nxt;
            Rw          <= rw_nxt;
            Rx_valid    <= rx_valid_nxt;
            Tx_req      <= tx_req_nxt;
            Addr_match  <= addr_match_nxt;
            Master_nack <= master_nack_nxt;
            Stop_det    <= stop_det_nxt;
        end
    end

    // byte_done marks "8th rise seen (or master ACK seen), act on the next SCL fall".
    always_comb begin
        state_nxt       = state;
        bit_cnt_nxt     = bit_cnt;
        shift_nxt       = shift_reg;
        byte_done_nxt   = byte_done;
        sda_oen_nxt     = Sda_oen;
        rx_data_nxt     = Rx_data;
        rw_nxt          = Rw;
        rx_valid_nxt    = 1'b0;
        tx_req_nxt      = 1'b0;
        addr_match_nxt  = 1'b0;
        master_nack_nxt = 1'b0;
        stop_det_nxt    = 1'b0;

        if (stop_cond) begin
            state_nxt     = IDLE;
            bit_cnt_nxt   = 3'd0;
            byte_done_nxt = 1'b0;
            sda_oen_nxt   = 1'b1;
            stop_det_nxt  = (state != IDLE);
        end else if (start_cond) begin
            state_nxt     = ADDR;
            bit_cnt_nxt   = 3'd0;
            byte_done_nxt = 1'b0;
            sda_oen_nxt   = 1'b1;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shift_nxt   = new_byte[6:0];
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (addr_hit) begin
                                rw_nxt         = new_byte[0];
                                addr_match_nxt = 1'b1;
                                tx_req_nxt     = new_byte[0];
                                byte_done_nxt  = 1'b1;
                            end else begin
                                state_nxt = WAIT_STOP;
                            end
                        end
                    end else if (scl_fall && byte_done) begin
                        byte_done_nxt = 1'b0;
                        sda_oen_nxt   = 1'b0;
                        state_nxt     = ADDR_ACK;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_nxt = 3'd0;
                        if (Rw) begin
                            shift_nxt   = Tx_data[6:0];
                            sda_oen_nxt = Tx_data[7];
                            state_nxt   = TX_BYTE;
                        end else begin
                            sda_oen_nxt = 1'b1;
                            state_nxt   = RX_BYTE;
                        end
                    end
                end
                RX_BYTE: begin
                    if (scl_rise) begin
                        shift_nxt   = new_byte[6:0];
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data_nxt   = new_byte;
                            rx_valid_nxt  = 1'b1;
                            byte_done_nxt = 1'b1;
                        end
                    end else if (scl_fall && byte_done) begin
                        byte_done_nxt = 1'b0;
                        if (Rx_nack) begin
                            state_nxt = WAIT_STOP;
                        end else begin
                            sda_oen_nxt = 1'b0;
                            state_nxt   = RX_ACK;
                        end
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        sda_oen_nxt = 1'b1;
                        bit_cnt_nxt = 3'd0;
                        state_nxt   = RX_BYTE;
                    end
                end
                TX_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_done_nxt = 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (byte_done) begin
                            byte_done_nxt = 1'b0;
                            sda_oen_nxt   = 1'b1;
                            state_nxt     = TX_ACK;
                        end else begin
                            sda_oen_nxt = shift_reg[6];
                            shift_nxt   = {shift_reg[5:0], 1'b1};
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            tx_req_nxt    = 1'b1;
                            byte_done_nxt = 1'b1;
                        end else begin
                            master_nack_nxt = 1'b1;
                            state_nxt       = WAIT_STOP;
                        end
                    end else if (scl_fall && byte_done) begin
                        byte_done_nxt = 1'b0;
                        bit_cnt_nxt   = 3'd0;
                        shift_nxt     = Tx_data[6:0];
                        sda_oen_nxt   = Tx_data[7];
                        state_nxt     = TX_BYTE;
                    end
                end
                IDLE, WAIT_STOP: begin
                    state_nxt = state;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// Scoreboard bench for i2c_slave_byte_ctrl: a bit-level I2C master drives the bus while monitors check
// SDA enable at every data clock and every output pulse against queued expectations.
module tb_i2c_slave_byte_ctrl;

    localparam int EV_ADDR  = 0;
    localparam int EV_RX    = 1;
    localparam int EV_TXREQ = 2;
    localparam int EV_MNACK = 3;
    localparam int EV_STOP  = 4;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       scl;
    logic       sda_m;
    logic       sda_line;
    logic       Sda_oen;
    logic [7:0] Rx_data;
    logic       Rx_valid;
    logic       Rx_nack;
    logic [7:0] Tx_data;
    logic       Tx_req;
    logic       Addr_match;
    logic       Rw;
    logic       Master_nack;
    logic       Stop_det;
    logic       Busy;
    logic       check_bit = 1'b0;

    ev_t  ev_q[$];
    logic bit_q[$];
    int   checks = 0;
    int   errors = 0;
    int   bit_idx = 0;

    assign sda_line = sda_m & Sda_oen;

    always #5 Clk = ~Clk;

    i2c_slave_byte_ctrl #(.SLAVE_ADDR(7'h50)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Scl_i      (scl),
        .Sda_i      (sda_line),
        .Sda_oen    (Sda_oen),
        .Rx_data    (Rx_data),
        .Rx_valid   (Rx_valid),
        .Rx_nack    (Rx_nack),
        .Tx_data    (Tx_data),
        .Tx_req     (Tx_req),
        .Addr_match (Addr_match),
        .Rw         (Rw),
        .Master_nack(Master_nack),
        .Stop_det   (Stop_det),
        .Busy       (Busy)
    );

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        ev_q.push_back(e);
    endtask

    task automatic take_event(input int kind, input logic [7:0] data);
        ev_t e;
        checks++;
        if (ev_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_event: got kind=%0d data=%h, expected no event", kind, data);
        end else begin
            e = ev_q.pop_front();
            if (e.kind != kind || e.data !== data) begin
                errors++;
                $display("[TB] FAIL event_order: got kind=%0d data=%h, expected kind=%0d data=%h",
                         kind, data, e.kind, e.data);
            end
        end
    endtask

    // Compares every output pulse, in a fixed priority order, against the queue front.
    task automatic monitor_pulses();
        forever begin
            @(negedge Clk);
            if (Addr_match)  take_event(EV_ADDR, {7'd0, Rw});
            if (Rx_valid)    take_event(EV_RX, Rx_data);
            if (Tx_req)      take_event(EV_TXREQ, 8'h00);
            if (Master_nack) take_event(EV_MNACK, 8'h00);
            if (Stop_det)    take_event(EV_STOP, 8'h00);
        end
    endtask

    task automatic monitor_bits();
        logic exp;
        forever begin
            @(posedge scl);
            if (check_bit) begin
                checks++;
                bit_idx++;
                if (bit_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL sda_oen_bit%0d: got %b, expected no data clock", bit_idx, Sda_oen);
                end else begin
                    exp = bit_q.pop_front();
                    if (Sda_oen !== exp) begin
                        errors++;
                        $display("[TB] FAIL sda_oen_bit%0d: got %b, expected %b", bit_idx, Sda_oen, exp);
                    end
                end
            end
        end
    endtask

    task automatic quarter();
        repeat (8) @(negedge Clk);
    endtask

    task automatic bus_start();
        if (!scl) begin
            sda_m = 1'b1;
            quarter();
            scl = 1'b1;
            quarter();
        end
        sda_m = 1'b0;
        quarter();
        scl = 1'b0;
        quarter();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        quarter();
        scl = 1'b1;
        quarter();
        sda_m = 1'b1;
        quarter();
        quarter();
    endtask

    task automatic clock_bit(input logic master_val, input logic exp_oen);
        sda_m = master_val;
        quarter();
        bit_q.push_back(exp_oen);
        check_bit = 1'b1;
        scl = 1'b1;
        quarter();
        quarter();
        scl = 1'b0;
        check_bit = 1'b0;
        quarter();
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack);
        for (int i = 7; i >= 0; i--) clock_bit(b[i], 1'b1);
        clock_bit(1'b1, exp_ack ? 1'b0 : 1'b1);
    endtask

    task automatic read_byte(input logic [7:0] b, input logic [7:0] next_tx, input logic master_ack);
        for (int i = 7; i >= 0; i--) clock_bit(1'b1, b[i]);
        Tx_data = next_tx;
        clock_bit(master_ack ? 1'b0 : 1'b1, 1'b1);
    endtask

    initial begin
        Rst_n   = 1'b0;
        scl     = 1'b1;
        sda_m   = 1'b1;
        Rx_nack = 1'b0;
        Tx_data = 8'h00;
        fork
            monitor_pulses();
            monitor_bits();
        join_none
        repeat (4) @(negedge Clk);
        check_output("reset_sda_oen", {7'd0, Sda_oen}, 8'h01);
        check_output("reset_rx_data", Rx_data, 8'h00);
        check_output("reset_rw", {7'd0, Rw}, 8'h00);
        check_output("reset_busy", {7'd0, Busy}, 8'h00);
        check_output("reset_pulses", {3'd0, Addr_match, Rx_valid, Tx_req, Master_nack, Stop_det}, 8'h00);
        Rst_n = 1'b1;
        repeat (4) @(negedge Clk);

        $display("[TB] write A0 3C");
        bus_start();
        expect_ev(EV_ADDR, 8'h00);
        write_byte(8'hA0, 1'b1);
        expect_ev(EV_RX, 8'h3C);
        write_byte(8'h3C, 1'b1);
        expect_ev(EV_STOP, 8'h00);
        bus_stop();
        check_output("t1_busy_after_stop", {7'd0, Busy}, 8'h00);

        $display("[TB] wrong address A2");
        bus_start();
        write_byte(8'hA2, 1'b0);
        write_byte(8'h55, 1'b0);
        check_output("t2_busy_wait_stop", {7'd0, Busy}, 8'h01);
        expect_ev(EV_STOP, 8'h00);
        bus_stop();
        check_output("t2_busy_after_stop", {7'd0, Busy}, 8'h00);
        check_output("t2_rx_data_held", Rx_data, 8'h3C);

        $display("[TB] read 96 5A");
        Tx_data = 8'h96;
        bus_start();
        expect_ev(EV_ADDR, 8'h01);
        expect_ev(EV_TXREQ, 8'h00);
        write_byte(8'hA1, 1'b1);
        expect_ev(EV_TXREQ, 8'h00);
        read_byte(8'h96, 8'h5A, 1'b1);
        expect_ev(EV_MNACK, 8'h00);
        read_byte(8'h5A, 8'h00, 1'b0);
        expect_ev(EV_STOP, 8'h00);
        bus_stop();

        $display("[TB] client nack");
        bus_start();
        expect_ev(EV_ADDR, 8'h00);
        write_byte(8'hA0, 1'b1);
        expect_ev(EV_RX, 8'h11);
        write_byte(8'h11, 1'b1);
        expect_ev(EV_RX, 8'h22);
        Rx_nack = 1'b1;
        write_byte(8'h22, 1'b0);
        Rx_nack = 1'b0;
        write_byte(8'h33, 1'b0);
        check_output("t4_busy_wait_stop", {7'd0, Busy}, 8'h01);
        check_output("t4_rx_data_kept", Rx_data, 8'h22);
        expect_ev(EV_STOP, 8'h00);
        bus_stop();

        $display("[TB] repeated start");
        bus_start();
        expect_ev(EV_ADDR, 8'h00);
        write_byte(8'hA0, 1'b1);
        expect_ev(EV_RX, 8'h10);
        write_byte(8'h10, 1'b1);
        Tx_data = 8'hC3;
        bus_start();
        check_output("t5_rw_kept_after_rstart", {7'd0, Rw}, 8'h00);
        expect_ev(EV_ADDR, 8'h01);
        expect_ev(EV_TXREQ, 8'h00);
        write_byte(8'hA1, 1'b1);
        expect_ev(EV_MNACK, 8'h00);
        read_byte(8'hC3, 8'h00, 1'b0);
        expect_ev(EV_STOP, 8'h00);
        bus_stop();

        $display("[TB] reset during ack");
        bus_start();
        expect_ev(EV_ADDR, 8'h00);
        for (int i = 7; i >= 0; i--) clock_bit(((8'hA0 >> i) & 8'h01) != 0, 1'b1);
        check_output("t6_ack_driven", {7'd0, Sda_oen}, 8'h00);
        Rst_n = 1'b0;
        #1;
        check_output("t6_reset_sda_oen", {7'd0, Sda_oen}, 8'h01);
        check_output("t6_reset_busy", {7'd0, Busy}, 8'h00);
        check_output("t6_reset_rw", {7'd0, Rw}, 8'h00);
        check_output("t6_reset_rx_data", Rx_data, 8'h00);
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        clock_bit(1'b1, 1'b1);
        check_output("t6_idle_after_reset", {7'd0, Busy}, 8'h00);
        bus_start();
        expect_ev(EV_ADDR, 8'h00);
        write_byte(8'hA0, 1'b1);
        expect_ev(EV_STOP, 8'h00);
        bus_stop();

        quarter();
        check_output("events_drained", 8'(ev_q.size()), 8'h00);
        check_output("bits_drained", 8'(bit_q.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
